// File: rtl/sha2_w_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : sha2_w_mem_if
// Brief    : Block-load / word-stream bundle between a SHA-2 round controller
//            and its message-schedule generator.
// Revision : 1.0 - initial release
// ============================================================================
interface sha2_w_mem_if #(
  parameter int WORD_W = 32
);
  logic [16*WORD_W-1:0] block;
  logic                 init;
  logic                 next;
  logic [WORD_W-1:0]    w;
  logic                 w_valid;
  logic [6:0]           round;
  logic                 done;

  // Round controller side
  modport master (
    output block, init, next,
    input  w, w_valid, round, done
  );

  // Schedule generator side
  modport slave (
    input  block, init, next,
    output w, w_valid, round, done
  );
endinterface
`default_nettype wire

// File: rtl/sha2_w_mem.sv
`default_nettype none
// ============================================================================
// Module   : sha2_w_mem
// Brief    : SHA-256 / SHA-512 message-schedule generator. Loads a 16-word
//            block and streams W[0..ROUNDS-1], one word per 'next' strobe,
//            through a 16-entry sliding window.
// Options  : SHA2_W_MEM_ZEROIZE_EN - clear the window whenever the schedule
//            leaves ACTIVE (last word consumed or reset).
// Revision : 1.0 - initial release
// ============================================================================
module sha2_w_mem #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic               clk,
  input  logic               reset,
  sha2_w_mem_if.slave        bus
);

  // Only the two standard SHA-2 word/round pairings are meaningful.
  generate
    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_params
      $error("sha2_w_mem: WORD_W/ROUNDS must be 32/64 or 64/80");
    end
  endgenerate

  // Rotate/shift amounts of the small sigma functions for each word size.
  localparam int S0_R1 = (WORD_W == 64) ? 1  : 7;
  localparam int S0_R2 = (WORD_W == 64) ? 8  : 18;
  localparam int S0_SH = (WORD_W == 64) ? 7  : 3;
  localparam int S1_R1 = (WORD_W == 64) ? 19 : 17;
  localparam int S1_R2 = (WORD_W == 64) ? 61 : 19;
  localparam int S1_SH = (WORD_W == 64) ? 6  : 10;

  localparam logic [6:0] C_LAST_ROUND = 7'(ROUNDS - 1);
  localparam logic [6:0] C_WIN_DEPTH  = 7'd16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [6:0]        r_t;
  logic [6:0]        w_t_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_load;
  logic              w_shift;
  logic              w_last;
  logic              w_active;
  logic [WORD_W-1:0] r_window [16];
  logic [WORD_W-1:0] w_s0;
  logic [WORD_W-1:0] w_s1;
  logic [WORD_W-1:0] w_new;
  logic [WORD_W-1:0] w_word;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Next expansion word: s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], wrapping.
  always_comb begin
    w_s0  = rotr(r_window[1], S0_R1) ^ rotr(r_window[1], S0_R2) ^ (r_window[1] >> S0_SH);
    w_s1  = rotr(r_window[14], S1_R1) ^ rotr(r_window[14], S1_R2) ^ (r_window[14] >> S1_SH);
    w_new = w_s1 + r_window[9] + w_s0 + r_window[0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control decode; init always takes priority over next.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.init) begin
          w_load      = 1'b1;
          w_t_nxt     = '0;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.init) begin
          w_load  = 1'b1;
          w_t_nxt = '0;
        end else if (bus.next) begin
          if (r_t == C_LAST_ROUND) begin
            w_last      = 1'b1;
            w_done_nxt  = 1'b1;
            w_t_nxt     = '0;
            w_state_nxt = IDLE;
          end else begin
            w_t_nxt = r_t + 7'd1;
            w_shift = (r_t >= C_WIN_DEPTH);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Round counter and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t    <= '0;
      r_done <= 1'b0;
    end else begin
      r_t    <= w_t_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Sliding window: load on init, shift in w_new once past the first 16 words.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef SHA2_W_MEM_ZEROIZE_EN
      if (r_state == ACTIVE) begin
        for (int i = 0; i < 16; i++) r_window[i] <= '0;
      end
`endif
    end else if (w_load) begin
      for (int i = 0; i < 16; i++) r_window[i] <= bus.block[(16-i)*WORD_W-1 -: WORD_W];
    end else if (w_last) begin
`ifdef SHA2_W_MEM_ZEROIZE_EN
      for (int i = 0; i < 16; i++) r_window[i] <= '0;
`endif
    end else if (w_shift) begin
      for (int i = 0; i < 15; i++) r_window[i] <= r_window[i+1];
      r_window[15] <= w_new;
    end
  end

  // Output word, forced to zero outside an active schedule.
  always_comb begin
    w_active = (r_state == ACTIVE);
    w_word   = '0;
    if (w_active) begin
      if (r_t < C_WIN_DEPTH) w_word = r_window[r_t[3:0]];
      else                   w_word = w_new;
    end
  end

  assign bus.w       = w_word;
  assign bus.w_valid = w_active;
  assign bus.round   = w_active ? r_t : 7'd0;
  assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sha2_w_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_w_mem
// Brief    : Self-checking bench for sha2_w_mem (32/64 and 64/80 instances)
//            against a textbook message-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha2_w_mem;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha2_w_mem_if #(.WORD_W(32)) b32 ();
  sha2_w_mem_if #(.WORD_W(64)) b64 ();

  sha2_w_mem #(.WORD_W(32), .ROUNDS(64)) u_dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  sha2_w_mem #(.WORD_W(64), .ROUNDS(80)) u_dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_w  [80];
  logic [63:0] seen_w [80];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ww);
    logic [31:0] v;
    v = x[31:0];
    if (ww == 32) return 64'((v >> n) | (v << (32 - n)));
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int ww);
    if (ww == 32) return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
    return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int ww);
    if (ww == 32) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
    return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
  endfunction

  // Standard recurrence over the whole W[] array.
  task automatic gen_sched(input logic [1023:0] blk, input int ww, input int rounds);
    logic [63:0] s;
    for (int i = 0; i < 16; i++)
      exp_w[i] = (ww == 32) ? 64'(blk[(16-i)*32-1 -: 32]) : blk[(16-i)*64-1 -: 64];
    for (int i = 16; i < rounds; i++) begin
      s = sig1(exp_w[i-2], ww) + exp_w[i-7] + sig0(exp_w[i-15], ww) + exp_w[i-16];
      exp_w[i] = (ww == 32) ? (s & 64'hFFFF_FFFF) : s;
    end
  endtask

  function automatic logic [511:0] rand_blk32();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [1023:0] rand_blk64();
    logic [1023:0] b;
    for (int k = 0; k < 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  // ---------------- 32-bit instance drivers (entered at a negedge) ----------------
  task automatic start32(input logic [511:0] blk, input logic with_next);
    gen_sched(1024'(blk), 32, 64);
    b32.block = blk;
    b32.init  = 1'b1;
    b32.next  = with_next;
    @(negedge clk);
    b32.init  = 1'b0;
    b32.next  = 1'b0;
  endtask

  task automatic consume32(input int from, input int to, input int max_gap);
    int gap;
    for (int i = from; i < to; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        b32.next = 1'b0;
        chk("stall_w32", 64'(b32.w), exp_w[i]);
        chk("stall_round32", 64'(b32.round), 64'(i));
        @(negedge clk);
      end
      chk("w32", 64'(b32.w), exp_w[i]);
      chk("round32", 64'(b32.round), 64'(i));
      chk("valid32", 64'(b32.w_valid), 64'd1);
      chk("nodone32", 64'(b32.done), 64'd0);
      seen_w[i] = 64'(b32.w);
      b32.next = 1'b1;
      @(negedge clk);
    end
    b32.next = 1'b0;
  endtask

  task automatic done32();
    chk("done32", 64'(b32.done), 64'd1);
    chk("done_valid32", 64'(b32.w_valid), 64'd0);
    chk("done_w32", 64'(b32.w), 64'd0);
    chk("done_round32", 64'(b32.round), 64'd0);
  endtask

  task automatic probe_zero(input string tag);
`ifdef SHA2_W_MEM_ZEROIZE_EN
    for (int k = 0; k < 16; k++) chk(tag, 64'(u_dut32.r_window[k]), 64'd0);
`else
    chk(tag, 64'(b32.w), 64'd0);
`endif
  endtask

  // ---------------- 64-bit instance drivers ----------------
  task automatic run64(input logic [1023:0] blk, input int max_gap);
    int gap;
    gen_sched(blk, 64, 80);
    b64.block = blk;
    b64.init  = 1'b1;
    @(negedge clk);
    b64.init  = 1'b0;
    for (int i = 0; i < 80; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        b64.next = 1'b0;
        chk("stall_w64", b64.w, exp_w[i]);
        @(negedge clk);
      end
      chk("w64", b64.w, exp_w[i]);
      chk("round64", 64'(b64.round), 64'(i));
      seen_w[i] = b64.w;
      b64.next = 1'b1;
      @(negedge clk);
    end
    b64.next = 1'b0;
    chk("done64", 64'(b64.done), 64'd1);
    chk("done_valid64", 64'(b64.w_valid), 64'd0);
    @(negedge clk);
    chk("done_once64", 64'(b64.done), 64'd0);
  endtask

  time t0;
  int  lat;

  initial begin
    reset = 1'b1;
    b32.block = '0; b32.init = 1'b0; b32.next = 1'b0;
    b64.block = '0; b64.init = 1'b0; b64.next = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(b32.w_valid), 64'd0);
    chk("rst_w", 64'(b32.w), 64'd0);
    chk("rst_round", 64'(b32.round), 64'd0);
    chk("rst_done", 64'(b32.done), 64'd0);
    chk("rst_valid64", 64'(b64.w_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // next while idle has no effect
    b32.next = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_next_valid", 64'(b32.w_valid), 64'd0);
    chk("idle_next_round", 64'(b32.round), 64'd0);
    chk("idle_next_done", 64'(b32.done), 64'd0);
    b32.next = 1'b0;
    @(negedge clk);

    // "abc" block, next held high
    t0 = $time;
    start32({32'h6162_6380, 448'd0, 32'h0000_0018}, 1'b0);
    consume32(0, 64, 0);
    lat = int'(($time - t0) / 10);
    chk("latency", 64'(lat), 64'd65);
    done32();
    chk("abc_w0", seen_w[0], 64'h6162_6380);
    chk("abc_w15", seen_w[15], 64'h0000_0018);
    chk("abc_w16", seen_w[16], 64'h6162_6380);
    chk("abc_w17", seen_w[17], 64'h000F_0000);
    probe_zero("zeroize_done");
    @(negedge clk);
    chk("done_once", 64'(b32.done), 64'd0);

    // random block with random next gaps
    start32(rand_blk32(), 1'b0);
    consume32(0, 64, 5);
    done32();

    // init at t=30 with a different block, together with next
    start32(rand_blk32(), 1'b0);
    consume32(0, 30, 1);
    start32(rand_blk32(), 1'b1);
    chk("restart_done", 64'(b32.done), 64'd0);
    consume32(0, 64, 0);
    done32();

    // init (with next) in the done cycle -> second schedule
    start32(rand_blk32(), 1'b1);
    chk("b2b_nodone", 64'(b32.done), 64'd0);
    consume32(0, 64, 0);
    done32();
    @(negedge clk);

    // reset at t=40
    start32(rand_blk32(), 1'b0);
    consume32(0, 40, 0);
    reset    = 1'b1;
    b32.next = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    b32.next = 1'b0;
    chk("abort_valid", 64'(b32.w_valid), 64'd0);
    chk("abort_w", 64'(b32.w), 64'd0);
    chk("abort_round", 64'(b32.round), 64'd0);
    chk("abort_done", 64'(b32.done), 64'd0);
    probe_zero("zeroize_reset");
    @(negedge clk);
    chk("abort_nodone", 64'(b32.done), 64'd0);

    // 64-bit / 80-round instance
    run64({64'h6162_6380_0000_0000, 896'd0, 64'h18}, 0);
    chk("abc64_w16", seen_w[16], 64'h6162_6380_0000_0000);
    chk("abc64_w17", seen_w[17], 64'h0003_0000_0000_00C0);
    run64(rand_blk64(), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
